mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_perf.sv | 41 ++++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_e;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_id_e;

    localparam int WAIT_CNT_W = 16;
    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/mem_arb_perf.sv
// Wrapping event counters for arbiter grants and request conflicts.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grant_i,
    input  logic                  grant_d,
    input  logic                  conflict,
    output logic [PERF_CNT_W-1:0] grant_i_cnt,
    output logic [PERF_CNT_W-1:0] grant_d_cnt,
    output logic [PERF_CNT_W-1:0] conflict_cnt
);

    logic [PERF_CNT_W-1:0] grant_i_cnt_q, grant_i_cnt_d;
    logic [PERF_CNT_W-1:0] grant_d_cnt_q, grant_d_cnt_d;
    logic [PERF_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant_i_cnt_d  = grant_i_cnt_q + PERF_CNT_W'(grant_i);
        grant_d_cnt_d  = grant_d_cnt_q + PERF_CNT_W'(grant_d);
        conflict_cnt_d = conflict_cnt_q + PERF_CNT_W'(conflict);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_i_cnt_q  <= '0;
            grant_d_cnt_q  <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_i_cnt_q  <= grant_i_cnt_d;
            grant_d_cnt_q  <= grant_d_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_i_cnt  = grant_i_cnt_q;
    assign grant_d_cnt  = grant_d_cnt_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one backing memory, with ack timeout and sticky err.
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDRESS_WIDTH-1:0]  if_addr,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_ready,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    input  logic [ADDRESS_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    output logic                      err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]     grant_i_cnt,
    output logic [PERF_CNT_W-1:0]     grant_d_cnt,
    output logic [PERF_CNT_W-1:0]     conflict_cnt
`endif
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

    arb_state_e                state_q, state_d;
    port_id_e                  last_q, last_d;
    logic [WAIT_CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [BE_WIDTH-1:0]       mem_be_q, mem_be_d;
    logic [ADDRESS_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]     d_rdata_q, d_rdata_d;
    logic                      if_ready_q, if_ready_d;
    logic                      d_ready_q, d_ready_d;
    logic                      err_q, err_d;
    logic                      gnt_fetch, gnt_data, timeout_hit;
    logic [DATA_WIDTH-1:0]     capture;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        gnt_fetch   = 1'b0;
        gnt_data    = 1'b0;
        timeout_hit = (wait_cnt_q + WAIT_CNT_W'(1)) == TIMEOUT_CNT;
        capture     = mem_ack ? mem_rdata : '0;

        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                gnt_data  = d_req && (!if_req || last_q == PORT_I);
                gnt_fetch = if_req && !gnt_data;
                if (gnt_data) begin
                    state_d     = BUSY_D;
                    last_d      = PORT_D;
                    wait_cnt_d  = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (gnt_fetch) begin
                    state_d     = BUSY_I;
                    last_d      = PORT_I;
                    wait_cnt_d  = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                // A timed-out transaction still completes, returning zero data.
                if (mem_ack || timeout_hit) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_I) begin
                        if_rdata_d = capture;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = capture;
                        d_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= PORT_I;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    assign conflict = (state_q == IDLE) && if_req && d_req;

    mem_arb_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .grant_i      (gnt_fetch),
        .grant_d      (gnt_data),
        .conflict     (conflict),
        .grant_i_cnt  (grant_i_cnt),
        .grant_d_cnt  (grant_d_cnt),
        .conflict_cnt (conflict_cnt)
    );
`endif

endmodule
